// File: rtl/c_frag_array_reg.sv
// c_frag_array_reg: an array of LANES top/bottom 4:1 mux fragment pairs.
// Each lane feeds a controlled stage-1 flop that supports clock enable,
// synchronous set/reset, direct-data bypass and a serial shift chain.
// An optional plain pipeline of 0-2 extra stages follows stage 1 and drives QZ.
module c_frag_array_reg #(
    parameter int               LANES   = 4,
    parameter int               PIPE    = 1,
    parameter logic [LANES-1:0] RST_VAL = {LANES{1'b0}}
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             QST,
    input  logic             QEN,
    input  logic             QDS,
    input  logic             SHIFT,
    input  logic             SI,
    input  logic [LANES-1:0] QDI,
    input  logic [LANES-1:0] TBS,
    input  logic [LANES-1:0] TAB,
    input  logic [LANES-1:0] TSL,
    input  logic [LANES-1:0] TA1,
    input  logic [LANES-1:0] TA2,
    input  logic [LANES-1:0] TB1,
    input  logic [LANES-1:0] TB2,
    input  logic [LANES-1:0] BAB,
    input  logic [LANES-1:0] BSL,
    input  logic [LANES-1:0] BA1,
    input  logic [LANES-1:0] BA2,
    input  logic [LANES-1:0] BB1,
    input  logic [LANES-1:0] BB2,
    output logic [LANES-1:0] TZ,
    output logic [LANES-1:0] CZ,
    output logic [LANES-1:0] QZ,
    output logic             SO
);

    // Out-of-range parameters stop elaboration rather than building a broken array.
    if (LANES < 1 || LANES > 32) begin : g_bad_lanes
        $error("c_frag_array_reg: LANES must be in 1..32");
    end
    if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
        $error("c_frag_array_reg: PIPE must be in 1..3");
    end

    logic [LANES-1:0] bz;
    logic [LANES-1:0] s1;
    logic [LANES-1:0] shift_next;

    // Bitwise mux forms keep every lane independent and carry no reset dependence.
    assign TZ = (TAB & ((TSL & TB2) | (~TSL & TB1))) |
                (~TAB & ((TSL & TA2) | (~TSL & TA1)));
    assign bz = (BAB & ((BSL & BB2) | (~BSL & BB1))) |
                (~BAB & ((BSL & BA2) | (~BSL & BA1)));
    assign CZ = (TBS & TZ) | (~TBS & bz);

    // Shift-chain next value: SI enters lane 0 and each lane takes its lower neighbour.
    // Written as a loop so LANES=1 collapses cleanly to just SI.
    always_comb begin
        shift_next    = '0;
        shift_next[0] = SI;
        for (int i = 1; i < LANES; i++) begin
            shift_next[i] = s1[i-1];
        end
    end

    // Stage-1 flop: reset beats set, both ignore the enable; shift beats data select.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            s1 <= RST_VAL;
        end else if (QST) begin
            s1 <= '1;
        end else if (QEN) begin
            if (SHIFT) begin
                s1 <= shift_next;
            end else if (QDS) begin
                s1 <= QDI;
            end else begin
                s1 <= CZ;
            end
        end
    end

    assign SO = s1[LANES-1];

    if (PIPE == 1) begin : g_no_pipe
        assign QZ = s1;
    end else begin : g_pipe
        logic [LANES-1:0] stage [PIPE-1];

        // Plain forward pipeline behind stage 1; only reset can disturb it.
        always_ff @(posedge QCK) begin
            if (QRT) begin
                for (int k = 0; k < PIPE-1; k++) begin
                    stage[k] <= RST_VAL;
                end
            end else begin
                stage[0] <= s1;
                for (int k = 1; k < PIPE-1; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end

        assign QZ = stage[PIPE-2];
    end

endmodule
